// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the write-back arbiter: register-file geometry,
// the write-back result record, and a one-hot helper for the pending-write scoreboard.
package wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN-1:0]       wdata;
    } wb_result_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        reg_onehot = NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO for MDU results, with an extra wrap bit on each pointer so that
// full and empty can be told apart. The head entry is read combinationally.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int WIDTH = REG_ADDR_W + XLEN,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges in-order ALU results with buffered MDU results onto the
// register-file write port, with starvation protection and a pending-MDU scoreboard.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN         = wb_arbiter_pkg::XLEN,
    parameter int MDU_DEPTH    = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_waddr,
    input  logic [XLEN-1:0]       alu_wdata,
    output logic                  alu_stall,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_waddr,
    input  logic [XLEN-1:0]       mdu_wdata,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_waddr,
    output logic [NUM_REGS-1:0]   pend_mask,
    output logic                  wen,
    output logic [REG_ADDR_W-1:0] regWAddr,
    output logic [XLEN-1:0]       regWData
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         push;
    logic                         pop;
    logic                         alu_sel;
    logic [REG_ADDR_W+XLEN-1:0]   head;
    logic [REG_ADDR_W-1:0]        head_waddr;
    logic [XLEN-1:0]              head_wdata;
    logic [REG_ADDR_W-1:0]        sel_waddr;
    logic [XLEN-1:0]              sel_wdata;
    logic [CW-1:0]                starve_cnt;
    logic [CW-1:0]                starve_next;
    logic [NUM_REGS-1:0]          pend_next;

    wb_fifo #(
        .WIDTH (REG_ADDR_W + XLEN),
        .DEPTH (MDU_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (push),
        .push_data ({mdu_waddr, mdu_wdata}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_waddr = head[XLEN +: REG_ADDR_W];
    assign head_wdata = head[XLEN-1:0];

    // Ready is gated by reset so the MDU sees no acceptance while state is being cleared.
    assign mdu_ready = !fifo_full && !reset;
    assign push      = mdu_valid && mdu_ready;
    assign alu_sel   = alu_valid && !alu_stall;
    assign pop       = !alu_sel && !fifo_empty;

    always_comb begin
        sel_waddr = head_waddr;
        sel_wdata = head_wdata;
        if (alu_sel) begin
            sel_waddr = alu_waddr;
            sel_wdata = alu_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wen      <= 1'b0;
            regWAddr <= '0;
            regWData <= '0;
        end else if ((alu_sel || pop) && (sel_waddr != '0)) begin
            wen      <= 1'b1;
            regWAddr <= sel_waddr;
            regWData <= sel_wdata;
        end else begin
            wen      <= 1'b0;
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        if (fifo_empty || pop)
            starve_next = '0;
        else if (alu_sel)
            starve_next = starve_cnt + 1'b1;
    end

    // Stall is registered from the next count so it is high in the very cycle the limit is hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
            alu_stall  <= 1'b0;
        end else begin
            starve_cnt <= starve_next;
            alu_stall  <= (starve_next == CW'(STARVE_LIMIT));
        end
    end

    // Clear first, then set, so a same-edge issue to a register being retired stays pending.
    always_comb begin
        pend_next = pend_mask;
        if (pop)
            pend_next = pend_next & ~reg_onehot(head_waddr);
        if (issue_valid && (issue_waddr != '0))
            pend_next = pend_next | reg_onehot(issue_waddr);
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pend_mask <= '0;
        else
            pend_mask <= pend_next;
    end

    a_no_alu_raw_on_pending: assert property (
        @(posedge clk) disable iff (reset)
        (alu_sel && (alu_waddr != '0)) |-> !pend_mask[alu_waddr]
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: each step drives inputs, advances one clock, and
// checks the registered outputs against hand-computed values.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        alu_stall;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_waddr;
    logic [31:0] mdu_wdata;
    logic        issue_valid;
    logic [4:0]  issue_waddr;
    logic [31:0] pend_mask;
    logic        wen;
    logic [4:0]  regWAddr;
    logic [31:0] regWData;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_waddr   (alu_waddr),
        .alu_wdata   (alu_wdata),
        .alu_stall   (alu_stall),
        .mdu_valid   (mdu_valid),
        .mdu_ready   (mdu_ready),
        .mdu_waddr   (mdu_waddr),
        .mdu_wdata   (mdu_wdata),
        .issue_valid (issue_valid),
        .issue_waddr (issue_waddr),
        .pend_mask   (pend_mask),
        .wen         (wen),
        .regWAddr    (regWAddr),
        .regWData    (regWData)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".wen"},  {31'd0, wen}, 32'd1);
        chk({tag, ".addr"}, {27'd0, regWAddr}, {27'd0, a});
        chk({tag, ".data"}, regWData, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        alu_valid   = 1'b0;
        alu_waddr   = '0;
        alu_wdata   = '0;
        mdu_valid   = 1'b0;
        mdu_waddr   = '0;
        mdu_wdata   = '0;
        issue_valid = 1'b0;
        issue_waddr = '0;

        #12;
        chk("rst.wen",   {31'd0, wen}, 32'd0);
        chk("rst.addr",  {27'd0, regWAddr}, 32'd0);
        chk("rst.data",  regWData, 32'd0);
        chk("rst.pend",  pend_mask, 32'd0);
        chk("rst.ready", {31'd0, mdu_ready}, 32'd0);
        chk("rst.stall", {31'd0, alu_stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel.ready", {31'd0, mdu_ready}, 32'd1);

        // ALU write, then idle
        alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'h1234;
        tick();
        chk_wr("t1.alu", 5'd5, 32'h1234);
        alu_valid = 1'b0;
        tick();
        chk("t1.idle.wen",  {31'd0, wen}, 32'd0);
        chk("t1.idle.addr", {27'd0, regWAddr}, 32'd5);

        // Issue x7, MDU returns it, drained with no ALU traffic
        issue_valid = 1'b1; issue_waddr = 5'd7;
        tick();
        chk("t2.pend.set", pend_mask, 32'h80);
        issue_valid = 1'b0;
        mdu_valid = 1'b1; mdu_waddr = 5'd7; mdu_wdata = 32'hDEAD;
        tick();
        chk("t2.hs.wen",  {31'd0, wen}, 32'd0);
        chk("t2.hs.pend", pend_mask, 32'h80);
        mdu_valid = 1'b0;
        tick();
        chk_wr("t2.pop", 5'd7, 32'hDEAD);
        chk("t2.pend.clr", pend_mask, 32'h0);
        tick();
        chk("t2.idle.wen", {31'd0, wen}, 32'd0);

        // Starvation: FIFO holds x9 while ALU wins every cycle
        issue_valid = 1'b1; issue_waddr = 5'd9;
        tick();
        chk("t3.pend", pend_mask, 32'h200);
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_waddr = 5'd10; alu_wdata = 32'h100;
        mdu_valid = 1'b1; mdu_waddr = 5'd9; mdu_wdata = 32'h99;
        tick();
        chk_wr("t3.alu0", 5'd10, 32'h100);
        chk("t3.stall0", {31'd0, alu_stall}, 32'd0);
        mdu_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            alu_waddr = 5'(10 + i); alu_wdata = 32'(32'h100 + i);
            tick();
            chk_wr($sformatf("t3.alu%0d", i), 5'(10 + i), 32'(32'h100 + i));
            chk($sformatf("t3.stall%0d", i), {31'd0, alu_stall}, {31'd0, i == 8});
        end
        alu_waddr = 5'd20; alu_wdata = 32'hAAAA;
        tick();
        chk_wr("t3.mdu", 5'd9, 32'h99);
        chk("t3.stall.clr", {31'd0, alu_stall}, 32'd0);
        chk("t3.pend.clr", pend_mask, 32'h0);
        tick();
        chk_wr("t3.held", 5'd20, 32'hAAAA);
        alu_valid = 1'b0;
        tick();
        chk("t3.idle.wen", {31'd0, wen}, 32'd0);

        // Three MDU results against a busy ALU: full after two, order preserved
        alu_valid = 1'b1; alu_waddr = 5'd20; alu_wdata = 32'h1;
        mdu_valid = 1'b1; mdu_waddr = 5'd11; mdu_wdata = 32'hB11;
        tick();
        chk("t4.rdy1", {31'd0, mdu_ready}, 32'd1);
        mdu_waddr = 5'd12; mdu_wdata = 32'hB12; alu_wdata = 32'h2;
        tick();
        chk("t4.rdy2", {31'd0, mdu_ready}, 32'd0);
        chk("t4.stall2", {31'd0, alu_stall}, 32'd0);
        mdu_waddr = 5'd13; mdu_wdata = 32'hB13;
        for (int k = 3; k <= 9; k++) begin
            alu_wdata = 32'(k);
            tick();
            chk($sformatf("t4.rdy%0d", k), {31'd0, mdu_ready}, 32'd0);
            chk($sformatf("t4.stall%0d", k), {31'd0, alu_stall}, {31'd0, k == 9});
        end
        alu_wdata = 32'h55;
        tick();
        chk_wr("t4.pop11", 5'd11, 32'hB11);
        chk("t4.rdy.after.pop", {31'd0, mdu_ready}, 32'd1);
        tick();
        chk_wr("t4.alu.held", 5'd20, 32'h55);
        chk("t4.rdy.full", {31'd0, mdu_ready}, 32'd0);
        mdu_valid = 1'b0; alu_valid = 1'b0;
        tick();
        chk_wr("t4.pop12", 5'd12, 32'hB12);
        tick();
        chk_wr("t4.pop13", 5'd13, 32'hB13);
        tick();
        chk("t4.idle.wen", {31'd0, wen}, 32'd0);

        // Writes to x0 are discarded; MDU x0 entry still pops; issue to x0 ignored
        alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'h1;
        issue_valid = 1'b1; issue_waddr = 5'd0;
        tick();
        chk("t5.alu.x0.wen", {31'd0, wen}, 32'd0);
        chk("t5.issue.x0",   pend_mask, 32'h0);
        alu_valid = 1'b0; issue_valid = 1'b0;
        mdu_valid = 1'b1; mdu_waddr = 5'd0; mdu_wdata = 32'h77;
        tick();
        mdu_valid = 1'b0;
        chk("t5.enq.ready", {31'd0, mdu_ready}, 32'd1);
        tick();
        chk("t5.mdu.x0.wen", {31'd0, wen}, 32'd0);
        tick();
        chk("t5.pop.wen", {31'd0, wen}, 32'd0);

        // Reset mid-operation with FIFO full and x7 pending
        issue_valid = 1'b1; issue_waddr = 5'd7;
        alu_valid = 1'b1; alu_waddr = 5'd25; alu_wdata = 32'hC0;
        mdu_valid = 1'b1; mdu_waddr = 5'd21; mdu_wdata = 32'hD21;
        tick();
        issue_valid = 1'b0;
        mdu_waddr = 5'd22; mdu_wdata = 32'hD22;
        tick();
        chk("t6.full.ready", {31'd0, mdu_ready}, 32'd0);
        chk("t6.pend",       pend_mask, 32'h80);
        chk_wr("t6.alu", 5'd25, 32'hC0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6.rst.wen",   {31'd0, wen}, 32'd0);
        chk("t6.rst.addr",  {27'd0, regWAddr}, 32'd0);
        chk("t6.rst.data",  regWData, 32'd0);
        chk("t6.rst.pend",  pend_mask, 32'd0);
        chk("t6.rst.ready", {31'd0, mdu_ready}, 32'd0);
        alu_valid = 1'b0; mdu_valid = 1'b0;
        tick();
        chk("t6.rst.ready2", {31'd0, mdu_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6.rel.ready", {31'd0, mdu_ready}, 32'd1);
        tick();
        chk("t6.rel.wen",  {31'd0, wen}, 32'd0);
        chk("t6.rel.pend", pend_mask, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
